mcp300x_scanner: RTL and testbench

- Multi-channel successor to the single-channel MCP3004/3008 reader.
- Runs a parametrised SPI mode-0 master against an MCP300x 10-bit ADC.
- Scans a masked set of channels in single-ended or differential mode, either once per request or continuously, and publishes each conversion as a valid-strobed stream plus a per-channel latest-value bank.
- Sits between the board clock domain and consumers such as the accel scaler and the 7-seg display driver.

---
 rtl/mcp300x_scanner_pkg.sv | 35 +++
 rtl/mcp300x_scanner_if.sv | 36 +++
 rtl/mcp300x_scanner_spi_clk_div.sv | 41 ++++
 rtl/mcp300x_scanner.sv | 189 ++++++++++++++++++
 tb/tb_mcp300x_scanner.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcp300x_scanner_pkg.sv
`default_nettype none
// ============================================================
// mcp300x_pkg : shared types, frame constants and scan helper
// Rev 1.0
// ============================================================
package mcp300x_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic [4:0] FRAME_SCLKS     = 5'd17;
  localparam logic [4:0] CMD_BITS        = 5'd5;
  localparam logic [4:0] NULL_EDGE       = 5'd7;
  localparam logic [4:0] FIRST_DATA_EDGE = 5'd8;

  // Next enabled channel above cur, wrapping; returns cur if it is the only one.
  // next_ch(mask, 3'd7) therefore yields the lowest enabled channel.
  function automatic logic [2:0] next_ch(input logic [7:0] mask, input logic [2:0] cur);
    logic [2:0] res;
    logic [2:0] idx;
    res = cur;
    for (int i = 7; i >= 1; i--) begin
      idx = cur + 3'(i);
      if (mask[idx]) res = idx;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcp300x_scanner_if.sv
`default_nettype none
// ============================================================
// mcp300x_scanner_if : control, SPI pins and result stream
// Rev 1.0
// ============================================================
interface mcp300x_scanner_if #(
  parameter int NUM_CH   = 8,
  parameter int RES_BITS = 10
);
  logic                       start;
  logic                       cont;
  logic                       diff;
  logic [NUM_CH-1:0]          ch_mask;
  logic                       sclk;
  logic                       cs_n;
  logic                       mosi;
  logic                       miso;
  logic                       busy;
  logic                       valid;
  logic [2:0]                 ch;
  logic [RES_BITS-1:0]        data;
  logic [NUM_CH*RES_BITS-1:0] bank;
  logic                       done;
  logic                       null_err;

  modport master (
    input  start, cont, diff, ch_mask, miso,
    output sclk, cs_n, mosi, busy, valid, ch, data, bank, done, null_err
  );

  modport slave (
    output start, cont, diff, ch_mask, miso,
    input  sclk, cs_n, mosi, busy, valid, ch, data, bank, done, null_err
  );
endinterface
`default_nettype wire

// File: rtl/mcp300x_scanner_spi_clk_div.sv
`default_nettype none
// ============================================================
// spi_clk_div : SCLK generator with rise/fall ticks, idle low
// Rev 1.0
// ============================================================
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  run_i,
  output logic rise_tick_o,
  output logic fall_tick_o,
  output logic sclk_o
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          sclk_q;
  logic          w_wrap;

  assign w_wrap = (cnt_q == CW'(CLK_DIV - 1));

  // Ticks fire on the last cycle of a half-period, so sclk_q flips on the same edge.
  always_ff @(posedge clk) begin
    if (rst || !run_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (w_wrap) begin
      cnt_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign rise_tick_o = run_i & w_wrap & ~sclk_q;
  assign fall_tick_o = run_i & w_wrap & sclk_q;
  assign sclk_o      = sclk_q;
endmodule
`default_nettype wire

// File: rtl/mcp300x_scanner.sv
`default_nettype none
// ============================================================
// mcp300x_scanner : masked multi-channel MCP300x SPI scanner
// Rev 1.0
// ============================================================
module mcp300x_scanner
  import mcp300x_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CLK_DIV     = 4,
  parameter int RES_BITS    = 10,
  parameter int IDLE_CYCLES = 16
) (
  input wire                 clk,
  input wire                 rst,
  mcp300x_scanner_if.master  bus
);
  localparam int CNT_MAX = (CLK_DIV > IDLE_CYCLES) ? CLK_DIV : IDLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t                     state_q;
  logic [CW-1:0]              cnt_q;
  logic [4:0]                 edge_q;
  logic [7:0]                 mask_q;
  logic                       diff_q;
  logic                       cont_mode_q;
  logic [2:0]                 cur_q;
  logic [9:0]                 res_q;
  logic                       cs_n_q;
  logic                       mosi_q;
  logic                       busy_q;
  logic                       valid_q;
  logic                       done_q;
  logic                       null_q;
  logic [2:0]                 ch_q;
  logic [RES_BITS-1:0]        data_q;
  logic [NUM_CH*RES_BITS-1:0] bank_q;

  logic       w_rise;
  logic       w_fall;
  logic       w_sclk;
  logic [7:0] w_mask8;
  logic [2:0] w_nxt;
  logic       w_last;
  logic [4:0] w_edge_n;
  logic [4:0] w_cmd;
  logic       w_mosi_nxt;
  logic       w_half_done;
  logic       w_gap_done;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk         (clk),
    .rst         (rst),
    .run_i       (state_q == SHIFT),
    .rise_tick_o (w_rise),
    .fall_tick_o (w_fall),
    .sclk_o      (w_sclk)
  );

  assign w_mask8     = 8'(bus.ch_mask);
  assign w_nxt       = next_ch(mask_q, cur_q);
  assign w_last      = (w_nxt <= cur_q);
  assign w_edge_n    = edge_q + 5'd1;
  assign w_cmd       = {1'b1, ~diff_q, cur_q};
  assign w_half_done = (cnt_q == CW'(CLK_DIV - 1));
  assign w_gap_done  = (cnt_q == CW'(IDLE_CYCLES - 1));

  // Bit presented after the fall that follows rise edge_q, i.e. for edge edge_q+1.
  always_comb begin
    w_mosi_nxt = 1'b0;
    if (edge_q < CMD_BITS) w_mosi_nxt = w_cmd[3'(CMD_BITS - 5'd1 - edge_q)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      edge_q      <= '0;
      mask_q      <= '0;
      diff_q      <= 1'b0;
      cont_mode_q <= 1'b0;
      cur_q       <= '0;
      res_q       <= '0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      null_q      <= 1'b0;
      ch_q        <= '0;
      data_q      <= '0;
      bank_q      <= '0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) null_q <= 1'b0;
          if ((bus.start || bus.cont) && (w_mask8 != 8'd0)) begin
            mask_q      <= w_mask8;
            diff_q      <= bus.diff;
            cont_mode_q <= bus.cont;
            cur_q       <= next_ch(w_mask8, 3'd7);
            state_q     <= SETUP;
            cnt_q       <= '0;
            edge_q      <= '0;
            cs_n_q      <= 1'b0;
            mosi_q      <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        SETUP: begin
          if (w_half_done) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SHIFT: begin
          if (w_rise) begin
            edge_q <= w_edge_n;
            if ((w_edge_n == NULL_EDGE) && bus.miso) null_q <= 1'b1;
            if (w_edge_n >= FIRST_DATA_EDGE) res_q <= {res_q[8:0], bus.miso};
          end
          if (w_fall) begin
            mosi_q <= w_mosi_nxt;
            if (edge_q == FRAME_SCLKS) begin
              state_q <= HOLD;
              cnt_q   <= '0;
            end
          end
        end
        HOLD: begin
          if (w_half_done) begin
            state_q <= GAP;
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
            valid_q <= 1'b1;
            ch_q    <= cur_q;
            data_q  <= res_q[9 -: RES_BITS];
            bank_q[int'(cur_q) * RES_BITS +: RES_BITS] <= res_q[9 -: RES_BITS];
            if (!cont_mode_q && w_last) done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (w_gap_done) begin
            if ((cont_mode_q && !bus.cont) || (!cont_mode_q && w_last) ||
                (w_last && (w_mask8 == 8'd0))) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              // Wrapping in continuous mode picks up the live mask and mode.
              if (w_last) begin
                mask_q <= w_mask8;
                diff_q <= bus.diff;
                cur_q  <= next_ch(w_mask8, 3'd7);
              end else begin
                cur_q <= w_nxt;
              end
              state_q <= SETUP;
              cnt_q   <= '0;
              edge_q  <= '0;
              cs_n_q  <= 1'b0;
              mosi_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sclk     = w_sclk;
  assign bus.cs_n     = cs_n_q;
  assign bus.mosi     = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.ch       = ch_q;
  assign bus.data     = data_q;
  assign bus.bank     = bank_q;
  assign bus.done     = done_q;
  assign bus.null_err = null_q;
endmodule
`default_nettype wire

// File: tb/tb_mcp300x_scanner.sv
`default_nettype none
// ============================================================
// tb_mcp300x_scanner : directed scoreboard bench with ADC model
// Rev 1.0
// ============================================================
module tb_mcp300x_scanner;
  localparam int NCH = 8;
  localparam int DIV = 2;
  localparam int RB  = 10;
  localparam int IDL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcp300x_scanner_if #(.NUM_CH(NCH), .RES_BITS(RB)) bus ();

  mcp300x_scanner #(
    .NUM_CH(NCH), .CLK_DIV(DIV), .RES_BITS(RB), .IDLE_CYCLES(IDL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [2:0] ch;
    logic [9:0] data;
    logic       done;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] cmd_q[$];
  int         npushed = 0;

  task automatic push_exp(input logic [2:0] c, input logic [9:0] d, input logic dn);
    exp_t e;
    e.ch = c; e.data = d; e.done = dn;
    exp_q.push_back(e);
    npushed++;
  endtask

  // ADC model: samples DIN on SCLK rise, drives DOUT after each SCLK fall.
  logic [9:0] val_tab [8];
  logic       null_force = 1'b0;
  logic       miso_r = 1'b0;
  int         rcnt = 0;
  logic [4:0] rx = '0;
  logic [2:0] mch = '0;
  assign bus.miso = miso_r;

  always @(negedge bus.cs_n or posedge bus.sclk) begin
    if (bus.sclk === 1'b1) begin
      logic [5:0] ecmd;
      rcnt++;
      if (rcnt <= 5) rx = {rx[3:0], bus.mosi};
      if (rcnt == 5) begin
        mch  = rx[2:0];
        ecmd = (cmd_q.size() > 0) ? {1'b0, cmd_q.pop_front()} : 6'h3F;
        chk("mosi_cmd", {1'b0, rx}, ecmd);
      end
    end else begin
      rcnt = 0;
      rx   = '0;
    end
  end

  always @(negedge bus.sclk) begin
    int n;
    n = rcnt + 1;
    if (n == 6)                 miso_r = 1'b1;
    else if (n == 7)            miso_r = null_force;
    else if (n >= 8 && n <= 17) miso_r = val_tab[mch][17 - n];
    else                        miso_r = 1'b0;
  end

  // Output monitor and scoreboard consumer.
  int   nvalid = 0, ndone = 0, cyc = 0, last_valid_cyc = 0, lowcnt = 0;
  logic prev_cs = 1'b1, prev_busy = 1'b0, prev_mosi = 1'b0;
  bit   abort_flag = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) abort_flag = 1'b1;
    if (bus.sclk === 1'b1) chk("mosi_stable_sclk_high", bus.mosi, prev_mosi);
    if (bus.cs_n === 1'b0) lowcnt++;
    else if (prev_cs === 1'b0) begin
      if (!abort_flag) chk("cs_low_cycles", lowcnt, 36 * DIV);
      lowcnt = 0;
      abort_flag = 1'b0;
    end
    if (bus.valid === 1'b1) begin
      nvalid++;
      last_valid_cyc = cyc;
      chk("valid_at_cs_rise", {bus.cs_n, prev_cs}, 2'b10);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("valid_ch", bus.ch, e.ch);
        chk("valid_data", bus.data, e.data);
        chk("bank_slice", bus.bank[e.ch * RB +: RB], e.data);
        chk("done_with_valid", bus.done, e.done);
      end else begin
        chk("valid_unexpected", nvalid, npushed);
      end
    end
    if (bus.done === 1'b1) begin
      ndone++;
      if (bus.valid !== 1'b1) chk("done_without_valid", bus.valid, 1'b1);
    end
    if (prev_busy === 1'b1 && bus.busy === 1'b0 && rst !== 1'b1)
      chk("busy_fall_after_gap", cyc - last_valid_cyc, IDL);
    prev_cs   = bus.cs_n;
    prev_busy = bus.busy;
    prev_mosi = bus.mosi;
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (bus.busy !== 1'b0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle_timeout", bus.busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, d0, k;
    bus.start = 1'b0; bus.cont = 1'b0; bus.diff = 1'b0; bus.ch_mask = '0;
    for (int i = 0; i < 8; i++) val_tab[i] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", bus.cs_n, 1'b1);
    chk("rst_sclk", bus.sclk, 1'b0);
    chk("rst_mosi", bus.mosi, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_null", bus.null_err, 1'b0);
    chk("rst_data", bus.data, 10'h0);
    chk("rst_ch", bus.ch, 3'h0);
    chk("rst_bank", bus.bank, 80'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single-shot, channels 0 and 2, single-ended.
    val_tab[0] = 10'h155; val_tab[2] = 10'h3FF;
    cmd_q.push_back(5'b11000); cmd_q.push_back(5'b11010);
    push_exp(3'd0, 10'h155, 1'b0); push_exp(3'd2, 10'h3FF, 1'b1);
    v0 = nvalid; d0 = ndone;
    bus.ch_mask = 8'b0000_0101;
    pulse_start();
    chk("t1_busy_set", bus.busy, 1'b1);
    wait_idle(2000);
    chk("t1_valids", nvalid - v0, 2);
    chk("t1_done", ndone - d0, 1);
    chk("t1_exp_drained", exp_q.size(), 0);

    // Continuous scan of all channels, cont dropped during second ch3 frame.
    for (int i = 0; i < 8; i++) val_tab[i] = 10'(i * 64);
    for (int i = 0; i < 12; i++) begin
      cmd_q.push_back({2'b11, 3'(i % 8)});
      push_exp(3'(i % 8), 10'((i % 8) * 64), 1'b0);
    end
    v0 = nvalid; d0 = ndone;
    bus.ch_mask = 8'hFF;
    bus.cont = 1'b1;
    k = 0;
    while (nvalid < v0 + 11 && k < 3000) begin @(negedge clk); k++; end
    chk("t2_wait_11", nvalid >= v0 + 11, 1'b1);
    k = 0;
    while (bus.cs_n !== 1'b0 && k < 100) begin @(negedge clk); k++; end
    chk("t2_ch3_frame_started", bus.cs_n, 1'b0);
    bus.cont = 1'b0;
    wait_idle(2000);
    chk("t2_valids", nvalid - v0, 12);
    chk("t2_no_done", ndone - d0, 0);
    chk("t2_exp_drained", exp_q.size(), 0);
    chk("t2_bank7", bus.bank[7 * RB +: RB], 10'h1C0);
    chk("t2_bank3", bus.bank[3 * RB +: RB], 10'h0C0);
    repeat (10) @(negedge clk);
    chk("t2_stays_idle", bus.busy, 1'b0);

    // Differential, channel 3.
    val_tab[3] = 10'h2A7;
    cmd_q.push_back(5'b10011);
    push_exp(3'd3, 10'h2A7, 1'b1);
    v0 = nvalid;
    bus.diff = 1'b1; bus.ch_mask = 8'h08;
    pulse_start();
    wait_idle(2000);
    bus.diff = 1'b0;
    chk("t3_valids", nvalid - v0, 1);
    repeat (5) @(negedge clk);
    chk("t3_data_hold", bus.data, 10'h2A7);
    chk("t3_ch_hold", bus.ch, 3'd3);

    // Null bit driven high: sticky until the next start.
    null_force = 1'b1;
    val_tab[0] = 10'h0AB;
    cmd_q.push_back(5'b11000);
    push_exp(3'd0, 10'h0AB, 1'b1);
    bus.ch_mask = 8'h01;
    pulse_start();
    wait_idle(2000);
    chk("t4_null_set", bus.null_err, 1'b1);
    repeat (20) @(negedge clk);
    chk("t4_null_sticky", bus.null_err, 1'b1);
    null_force = 1'b0;
    cmd_q.push_back(5'b11000);
    push_exp(3'd0, 10'h0AB, 1'b1);
    pulse_start();
    chk("t4_null_cleared", bus.null_err, 1'b0);
    wait_idle(2000);
    chk("t4_null_stays_clear", bus.null_err, 1'b0);

    // Reset at SCLK rise 10 aborts the frame.
    v0 = nvalid;
    cmd_q.push_back(5'b11000);
    pulse_start();
    k = 0;
    while (rcnt < 10 && k < 200) begin @(negedge clk); k++; end
    chk("t5_reached_edge10", rcnt, 10);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_cs_n_high", bus.cs_n, 1'b1);
    chk("t5_sclk_low", bus.sclk, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_valid", nvalid - v0, 0);
    chk("t5_bank_clear", bus.bank, 80'h0);
    chk("t5_busy_clear", bus.busy, 1'b0);
    cmd_q.push_back(5'b11000);
    push_exp(3'd0, 10'h0AB, 1'b1);
    pulse_start();
    wait_idle(2000);
    chk("t5_clean_frame", nvalid - v0, 1);

    // Empty mask does nothing; start while busy is ignored.
    bus.ch_mask = 8'h00;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      chk("t6_mask0_busy", bus.busy, 1'b0);
      chk("t6_mask0_cs_n", bus.cs_n, 1'b1);
      @(negedge clk);
    end
    val_tab[2] = 10'h3C3;
    cmd_q.push_back(5'b11010);
    push_exp(3'd2, 10'h3C3, 1'b1);
    v0 = nvalid;
    bus.ch_mask = 8'h04;
    pulse_start();
    repeat (20) @(negedge clk);
    bus.ch_mask = 8'h02;
    pulse_start();
    wait_idle(2000);
    repeat (30) @(negedge clk);
    chk("t6_one_scan", nvalid - v0, 1);
    chk("t6_idle", bus.busy, 1'b0);
    chk("t6_exp_drained", exp_q.size(), 0);
    chk("t6_cmd_drained", cmd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
